// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg
// Shared definitions for the latch_bank_arbiter slice:
//   - FSM state encoding (ST_IDLE, ST_GRANT, ST_DONE)
//   - default parameter constants (N, AW, DW, IW)
//   - rr_pick(): round-robin winner selection over up to 8 requesters
package latch_bank_pkg;

  localparam int N_DEF  = 4;
  localparam int AW_DEF = 3;
  localparam int DW_DEF = 8;
  localparam int IW_DEF = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Scan ptr, ptr+1, ..., wrapping modulo n; first set bit wins.
  // req is zero-extended to 8 bits by the caller; returns 0 when req is empty.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (!found && req[idx[2:0]]) begin
          win   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/latch_bank_arbiter_rr_pick_n.sv
// latch_bank_arbiter_rr_pick_n
// Combinational round-robin priority picker.
// Ports:
//   req    [N-1:0]  request levels
//   ptr    [IW-1:0] highest-priority index for this arbitration
//   winner [IW-1:0] index of the first set request at or after ptr (mod N)
module rr_pick_n
  import latch_bank_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner
);

  logic [7:0] req8;
  logic [2:0] ptr3;
  logic [2:0] pick;

  always_comb begin
    req8         = '0;
    req8[N-1:0]  = req;
    ptr3         = 3'(ptr);
    pick         = rr_pick(req8, ptr3, N);
    winner       = IW'(pick);
  end

endmodule

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
// Round-robin arbiter/sequencer sharing one DEPTH x DW register bank among
// N requesters. Each access takes IDLE (capture) -> GRANT (bank access) ->
// DONE (ack pulse), so one transaction completes every 3 cycles.
//
// state | meaning
// IDLE  | wait for any req; pick winner, capture its we/addr/wdata
// GRANT | perform write to bank or read into rdata
// DONE  | ack[gnt_id] high for one cycle; advance round-robin pointer
//
// Ports:
//   clk, rst           clock, async active-high reset
//   req/we   [N]       request level and write enable per requester
//   addr     [N*AW]    packed addresses, requester i at [i*AW +: AW]
//   wdata    [N*DW]    packed write data, requester i at [i*DW +: DW]
//   lock     [N]       (only with LATCH_BANK_ARB_LOCK_EN) hold pointer on
//                      the granted requester so it wins next time
//   ack      [N]       one-hot, one-cycle completion pulse
//   rdata    [DW]      read data, valid with ack; held across writes
//   busy               high in GRANT and DONE
//   gnt_id   [IW]      current or last granted requester
// Optional feature macro: LATCH_BANK_ARB_LOCK_EN
module latch_bank_arbiter
  import latch_bank_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
`ifdef LATCH_BANK_ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    ack,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic [IW-1:0]   gnt_id
);

  localparam int DEPTH = 1 << AW;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] bank [DEPTH];

  logic [IW-1:0] winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [N-1:0]  gnt_onehot;
  logic          hold_ptr;
  logic [IW-1:0] ptr_next;

  rr_pick_n #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner)
  );

  // Constant-slice muxes keep the packed-bus selection width-clean.
  always_comb begin
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    gnt_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IW'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
      gnt_onehot[i] = (gnt_id == IW'(i));
    end
  end

  always_comb begin
    hold_ptr = 1'b0;
`ifdef LATCH_BANK_ARB_LOCK_EN
    hold_ptr = |(lock & gnt_onehot);
`endif
    if (hold_ptr)
      ptr_next = gnt_id;
    else if (gnt_id == IW'(N - 1))
      ptr_next = '0;
    else
      ptr_next = gnt_id + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack     <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      gnt_id  <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= '0;
          if (|req) begin
            gnt_id  <= winner;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            busy    <= 1'b1;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (we_q)
            bank[addr_q] <= wdata_q;
          else
            rdata <= bank[addr_q];
          ack   <= gnt_onehot;
          state <= ST_DONE;
        end
        ST_DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          ptr   <= ptr_next;
          state <= ST_IDLE;
        end
        default: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
module tb_latch_bank_arbiter;
  localparam int N = 4, AW = 3, DW = 8, IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    lock;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [IW-1:0]   gnt_id;

  latch_bank_arbiter #(.N(N), .AW(AW), .DW(DW), .IW(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
`ifdef LATCH_BANK_ARB_LOCK_EN
    .lock   (lock),
`endif
    .ack    (ack),
    .rdata  (rdata),
    .busy   (busy),
    .gnt_id (gnt_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bank contents, pointer and last read value.
  int m_bank [8];
  int m_ptr;
  int m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = 0;
    m_ptr   = 0;
    m_rdata = 0;
  endtask

  task automatic set_req(input int i, input bit w, input int a, input int d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = a[AW-1:0];
    wdata[i*DW +: DW] = d[DW-1:0];
  endtask

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE and req != 0.
  // Runs the full 3-cycle transaction and checks each cycle.
  task automatic serve_one(output int w);
    bit wr;
    int a, d;
    w  = m_pick();
    wr = we[w];
    a  = int'(addr[w*AW +: AW]);
    d  = int'(wdata[w*DW +: DW]);
    @(posedge clk); #1;
    check("grant_busy", 32'(busy), 1);
    check("grant_id", 32'(gnt_id), 32'(w));
    check("grant_ack", 32'(ack), 0);
    @(posedge clk); #1;
    if (wr) m_bank[a] = d; else m_rdata = m_bank[a];
    check("done_ack", 32'(ack), 32'(1 << w));
    check("done_rdata", 32'(rdata), 32'(m_rdata));
    check("done_busy", 32'(busy), 1);
    req[w] = 1'b0;
`ifdef LATCH_BANK_ARB_LOCK_EN
    m_ptr = lock[w] ? w : (w + 1) % N;
`else
    m_ptr = (w + 1) % N;
`endif
    @(posedge clk); #1;
    check("idle_ack", 32'(ack), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_id", 32'(gnt_id), 32'(w));
  endtask

  initial begin
    int w;
    req = '0; we = '0; addr = '0; wdata = '0; lock = '0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt_id), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_noreq_busy", 32'(busy), 0);

    // Single write then read by requester 1.
    set_req(1, 1'b1, 5, 8'hA5);
    serve_one(w);
    check("wr1_id", 32'(w), 1);
    set_req(1, 1'b0, 5, 0);
    serve_one(w);
    check("rd1_data", 32'(rdata), 32'h A5);

    // Force ptr back to 0 via requester 3, then all four read at once.
    set_req(3, 1'b0, 0, 0);
    serve_one(w);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 0);
    for (int k = 0; k < N; k++) begin
      serve_one(w);
      check("all4_order", 32'(w), 32'(k));
    end

    // Last grant 2 -> ptr=3; then 3 and 0 together: 3 first, then 0.
    set_req(2, 1'b0, 1, 0);
    serve_one(w);
    set_req(3, 1'b0, 5, 0);
    set_req(0, 1'b0, 5, 0);
    serve_one(w);
    check("wrap_first", 32'(w), 3);
    serve_one(w);
    check("wrap_second", 32'(w), 0);

    // Write by 2 and read by 3 of addr 7 in the same cycle (ptr=1).
    set_req(2, 1'b1, 7, 8'h3C);
    set_req(3, 1'b0, 7, 0);
    serve_one(w);
    check("raw_first", 32'(w), 2);
    serve_one(w);
    check("raw_second", 32'(w), 3);
    check("raw_data", 32'(rdata), 32'h3C);

    // Reset during GRANT of a write to addr 2.
    set_req(0, 1'b1, 2, 8'h77);
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #2;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ack", 32'(ack), 0);
    req = '0;
    model_reset();
    @(posedge clk); #1;
    check("midrst_noack", 32'(ack), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    set_req(1, 1'b0, 2, 0);
    serve_one(w);
    check("post_rst_id", 32'(w), 1);
    check("post_rst_rd", 32'(rdata), 0);

`ifdef LATCH_BANK_ARB_LOCK_EN
    // ptr=2 now; use requester 0 to move ptr to 1.
    set_req(0, 1'b0, 0, 0);
    serve_one(w);
    lock[1] = 1'b1;
    set_req(1, 1'b0, 3, 0);
    set_req(2, 1'b0, 4, 0);
    serve_one(w);
    check("lock_first", 32'(w), 1);
    set_req(1, 1'b0, 3, 0);
    lock[1] = 1'b0;
    serve_one(w);
    check("lock_second", 32'(w), 1);
    set_req(1, 1'b0, 3, 0);
    serve_one(w);
    check("lock_release", 32'(w), 2);
    req = '0;
`endif

    // Randomized traffic: pending requests are held until served.
    for (int r = 0; r < 80; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)));
      end
`ifdef LATCH_BANK_ARB_LOCK_EN
      lock = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
`endif
      if (req == '0) begin
        @(posedge clk); #1;
        check("rand_idle_busy", 32'(busy), 0);
      end else begin
        serve_one(w);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
